div_request_sequencer: RTL
==========================

// Module: div_request_sequencer
// PURPOSE
// Front-end and back-end for the iterative restoring divider. Buffers divide requests
// (dividend, divisor, sign, tag) in a small FIFO. Launches one divider operation at a
// time with a single-cycle start pulse and captures quotient/remainder on the divider's
// ready pulse. Returns results in request order over a valid/ready handshake, and
// handles divide-by-zero and divider watchdog timeout locally.
// PARAMETERS
// WIDTH    8          operand/result width, matches divider WIDTH
// DEPTH    4          request FIFO entries, power of 2, >=2
// TAG_W    4          width of opaque request tag, returned unchanged
// TIMEOUT  WIDTH+4    max cycles in WAIT before forced completion
// PORTS
// clk            in   1                  system clock, all logic posedge
// reset          in   1                  synchronous, active-high
// in_valid       in   1                  request present
// in_ready       out  1                  FIFO can accept (= !full)
// in_dividend    in   WIDTH              request dividend
// in_divisor     in   WIDTH              request divisor
// in_sign        in   1                  0 unsigned, 1 two's complement
// in_tag         in   TAG_W              request tag
// count          out  $clog2(DEPTH+1)    FIFO occupancy
// div_start      out  1                  one-cycle launch pulse to divider
// div_sign       out  1                  held operand to divider
// div_dividend   out  WIDTH              held operand to divider
// div_divisor    out  WIDTH              held operand to divider
// div_ready      in   1                  divider done, one-cycle pulse
// div_quotient   in   WIDTH              divider result, valid when div_ready=1
// div_remainder  in   WIDTH              divider result, valid when div_ready=1
// out_valid      out  1                  result held
// out_ready      in   1                  consumer accepts
// out_quotient   out  WIDTH              result quotient
// out_remainder  out  WIDTH              result remainder
// out_tag        out  TAG_W              tag of the completed request
// out_dbz        out  1                  divisor was zero
// out_timeout    out  1                  watchdog fired; q/r invalid
// BEHAVIOUR
// - Reset: FIFO empty, count=0, state IDLE, in_ready=1, div_start=0, out_valid=0.
//   Reset also clears out_* regs and div_* operand regs to 0 and the watchdog to 0.
// - Push when in_valid&&in_ready. Pop only on IDLE->ISSUE/DBZ. Simultaneous push+pop
//   keeps count; push while full impossible (in_ready=0). Pointers wrap modulo DEPTH.
// - FSM IDLE: if FIFO non-empty, pop head, latch operands+tag; divisor==0 -> DBZ else ISSUE.
// - ISSUE (1 cycle): div_start=1, div_* operands stable; div_ready ignored; clear watchdog -> WAIT.
// - WAIT: watchdog++ each cycle. div_ready=1 -> capture div_quotient/remainder, -> DONE.
//   watchdog==TIMEOUT-1 without div_ready -> q=r=0, out_timeout=1, -> DONE.
// - DBZ (1 cycle): q={WIDTH{1}}, r=dividend, out_dbz=1, no div_start -> DONE.
// - DONE: out_valid=1; outputs stable until out_valid&&out_ready, then -> IDLE. Flags clear on next capture.
// - Latency, FIFO empty, out_ready=1: push at cycle 0; IDLE pops at 1; ISSUE at 2.
//   out_valid rises the cycle after div_ready is sampled; DBZ out_valid at cycle 3.
// - div_start is never asserted outside ISSUE. A stale div_ready in IDLE/DONE/DBZ is ignored.
// - Reset mid-operation: state->IDLE, FIFO flushed, pending result dropped. The divider
//   (no reset) is restarted by the next div_start, so its in-flight result is discarded.
// - Operands pass unmodified; sign handling is the divider's.
// TESTING (WIDTH=8, DEPTH=4, TAG_W=4, TIMEOUT=12, behavioural divider model)
// 1 unsigned 100/7 tag 3 -> out q=14 r=2 tag=3 dbz=0 timeout=0; exactly one div_start.
// 2 signed 0xF9/0x02 (-7/2) -> q=0xFD r=0xFF.
// 3 55/0 -> q=0xFF r=55 out_dbz=1; out_valid at cycle 3; div_start never asserted.
// 4 out_ready=0, 6 back-to-back pushes -> 5 accepted, in_ready low with count=4.
//   Then release out_ready -> results in push order, tags intact, count drains to 0.
// 5 divider model never pulses ready -> out_timeout=1 after 12 WAIT cycles; next request still correct.
// 6 reset asserted in WAIT with 2 queued -> count=0, out_valid=0. Fresh 9/3 then gives q=3 r=0 with
//   no stale result.

Source files
------------

// File: rtl/div_request_sequencer.sv
// Request FIFO plus launch/capture sequencer around an iterative divider.
// Results come back in request order; divide-by-zero and divider stalls are resolved locally.
module div_request_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = WIDTH + 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_dividend,
  input  logic [WIDTH-1:0]           in_divisor,
  input  logic                       in_sign,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       div_start,
  output logic                       div_sign,
  output logic [WIDTH-1:0]           div_dividend,
  output logic [WIDTH-1:0]           div_divisor,
  input  logic                       div_ready,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic [WIDTH-1:0]           div_remainder,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_quotient,
  output logic [WIDTH-1:0]           out_remainder,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       out_dbz,
  output logic                       out_timeout
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DBZ, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem_dividend [DEPTH];
  logic [WIDTH-1:0]   mem_divisor  [DEPTH];
  logic               mem_sign     [DEPTH];
  logic [TAG_W-1:0]   mem_tag      [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [WDW-1:0]     watchdog;
  logic [TAG_W-1:0]   cur_tag;
  logic               push;
  logic               pop;

  assign in_ready = (count != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_dividend[wr_ptr] <= in_dividend;
      mem_divisor[wr_ptr]  <= in_divisor;
      mem_sign[wr_ptr]     <= in_sign;
      mem_tag[wr_ptr]      <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      watchdog      <= '0;
      cur_tag       <= '0;
      div_start     <= 1'b0;
      div_sign      <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_tag       <= '0;
      out_dbz       <= 1'b0;
      out_timeout   <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so increment wraps modulo DEPTH.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            div_dividend <= mem_dividend[rd_ptr];
            div_divisor  <= mem_divisor[rd_ptr];
            div_sign     <= mem_sign[rd_ptr];
            cur_tag      <= mem_tag[rd_ptr];
            if (mem_divisor[rd_ptr] == '0) begin
              state <= DBZ;
            end else begin
              state     <= ISSUE;
              div_start <= 1'b1;
            end
          end
        end
        ISSUE: begin
          watchdog <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          watchdog <= watchdog + 1'b1;
          if (div_ready) begin
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_tag       <= cur_tag;
            out_dbz       <= 1'b0;
            out_timeout   <= 1'b0;
            out_valid     <= 1'b1;
            state         <= DONE;
          end else if (watchdog == WDW'(TIMEOUT - 1)) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_tag       <= cur_tag;
            out_dbz       <= 1'b0;
            out_timeout   <= 1'b1;
            out_valid     <= 1'b1;
            state         <= DONE;
          end
        end
        DBZ: begin
          out_quotient  <= '1;
          out_remainder <= div_dividend;
          out_tag       <= cur_tag;
          out_dbz       <= 1'b1;
          out_timeout   <= 1'b0;
          out_valid     <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
